// File: rtl/jump_sequencer.sv
// Fetch-side jump initiator: owns the PC, detects J/JAL/JR, and hands the
// request to the jump unit, resuming fetch at the returned target.
module jump_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd1,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  output logic        jmp_en,
  output logic        jmp_jump,
  output logic [31:0] jmp_pc,
  output logic [25:0] jmp_addr,
  output logic [3:0]  jmp_path_index,
  output logic [31:0] jmp_reg_addr,
  input  logic [31:0] jmp_pc_out,
  input  logic        jmp_done,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [3:0] PATH_J   = 4'd6;
  localparam logic [3:0] PATH_JAL = 4'd7;
  localparam logic [3:0] PATH_JR  = 4'd8;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          pc_valid_q, pc_valid_d;
  logic          jmp_en_q, jmp_en_d;
  logic [31:0]   jmp_pc_q, jmp_pc_d;
  logic [25:0]   jmp_addr_q, jmp_addr_d;
  logic [3:0]    jmp_path_q, jmp_path_d;
  logic [31:0]   jmp_reg_q, jmp_reg_d;
  logic          link_we_q, link_we_d;
  logic [31:0]   link_data_q, link_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  logic       is_j, is_jal, is_jr, is_jump;
  logic [3:0] path_sel;

  always_comb begin
    is_j     = (instr[31:26] == 6'h02);
    is_jal   = (instr[31:26] == 6'h03);
    is_jr    = (instr[31:26] == 6'h00) && (instr[5:0] == 6'h08);
    is_jump  = is_j | is_jal | is_jr;
    path_sel = is_j ? PATH_J : (is_jal ? PATH_JAL : PATH_JR);
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_valid_d  = pc_valid_q;
    jmp_en_d    = jmp_en_q;
    jmp_pc_d    = jmp_pc_q;
    jmp_addr_d  = jmp_addr_q;
    jmp_path_d  = jmp_path_q;
    jmp_reg_d   = jmp_reg_q;
    link_we_d   = 1'b0;
    link_data_d = link_data_q;
    cnt_d       = cnt_q;
    terr_d      = terr_q;
    case (state_q)
      S_RUN: begin
        if (!stall) begin
          if (is_jump) begin
            state_d    = S_WAIT;
            pc_valid_d = 1'b0;
            jmp_en_d   = 1'b1;
            jmp_pc_d   = pc_q;
            jmp_addr_d = instr[25:0];
            jmp_path_d = path_sel;
            jmp_reg_d  = rs_data;
            cnt_d      = '0;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end
      S_WAIT: begin
        // done takes priority over the timeout expiring in the same cycle
        if (jmp_done) begin
          state_d    = S_RUN;
          pc_d       = jmp_pc_out;
          pc_valid_d = 1'b1;
          jmp_en_d   = 1'b0;
          if (jmp_path_q == PATH_JAL) begin
            link_we_d   = 1'b1;
            link_data_d = jmp_pc_q + PC_STEP;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d  = S_FAULT;
          jmp_en_d = 1'b0;
          terr_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        jmp_en_d   = 1'b0;
        pc_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      pc_valid_q  <= 1'b1;
      jmp_en_q    <= 1'b0;
      jmp_pc_q    <= '0;
      jmp_addr_q  <= '0;
      jmp_path_q  <= '0;
      jmp_reg_q   <= '0;
      link_we_q   <= 1'b0;
      link_data_q <= '0;
      cnt_q       <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_valid_q  <= pc_valid_d;
      jmp_en_q    <= jmp_en_d;
      jmp_pc_q    <= jmp_pc_d;
      jmp_addr_q  <= jmp_addr_d;
      jmp_path_q  <= jmp_path_d;
      jmp_reg_q   <= jmp_reg_d;
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
      cnt_q       <= cnt_d;
      terr_q      <= terr_d;
    end
  end

  assign jmp_en         = jmp_en_q;
  assign jmp_jump       = jmp_en_q;
  assign jmp_pc         = jmp_pc_q;
  assign jmp_addr       = jmp_addr_q;
  assign jmp_path_index = jmp_path_q;
  assign jmp_reg_addr   = jmp_reg_q;
  assign pc             = pc_q;
  assign pc_valid       = pc_valid_q;
  assign link_we        = link_we_q;
  assign link_data      = link_data_q;
  assign busy           = (state_q == S_WAIT);
  assign timeout_err    = terr_q;

endmodule

// File: tb/tb_jump_sequencer.sv
// Directed bench for jump_sequencer: each scenario task drives vectors and
// checks against hand-computed values.
module tb_jump_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [31:0] rs_data = 32'h0;
  logic [31:0] jmp_pc_out = 32'h0;
  logic        jmp_done = 1'b0;
  logic        jmp_en, jmp_jump, pc_valid, link_we, busy, timeout_err;
  logic [31:0] jmp_pc, jmp_reg_addr, pc, link_data;
  logic [25:0] jmp_addr;
  logic [3:0]  jmp_path_index;

  int passed = 0;
  int total  = 0;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] ADD   = 32'h0022_1820;
  localparam logic [31:0] J5    = {6'h02, 26'd5};
  localparam logic [31:0] JAL0  = {6'h03, 26'd0};
  localparam logic [31:0] JR_R1 = {6'h00, 5'd1, 15'd0, 6'h08};

  jump_sequencer #(.RESET_PC(32'd0), .PC_STEP(32'd1), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .instr(instr), .rs_data(rs_data),
    .jmp_en(jmp_en), .jmp_jump(jmp_jump), .jmp_pc(jmp_pc), .jmp_addr(jmp_addr),
    .jmp_path_index(jmp_path_index), .jmp_reg_addr(jmp_reg_addr),
    .jmp_pc_out(jmp_pc_out), .jmp_done(jmp_done), .pc(pc), .pc_valid(pc_valid),
    .link_we(link_we), .link_data(link_data), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; instr = NOP; rs_data = '0;
    jmp_done = 1'b0; jmp_pc_out = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic advance(input int n);
    instr = NOP;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (pc !== 32'd0 || pc_valid !== 1'b1 || jmp_en !== 1'b0 || jmp_jump !== 1'b0 ||
        busy !== 1'b0 || timeout_err !== 1'b0 || link_we !== 1'b0 || link_data !== 32'd0 ||
        jmp_pc !== 32'd0 || jmp_path_index !== 4'd0)
      $display("FAIL reset: pc=%h pv=%b en=%b busy=%b terr=%b lwe=%b exp pc=0 pv=1 others 0",
               pc, pc_valid, jmp_en, busy, timeout_err, link_we);
    else passed++;
  endtask

  task automatic test_sequential();
    do_reset();
    instr = NOP;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (pc !== 32'(i) || pc_valid !== 1'b1 || jmp_en !== 1'b0)
        $display("FAIL seq_pc%0d: pc=%h pv=%b en=%b exp pc=%0d pv=1 en=0", i, pc, pc_valid, jmp_en, i);
      else passed++;
    end
    instr = ADD;
    step();
    total++;
    if (pc !== 32'd4 || jmp_en !== 1'b0)
      $display("FAIL seq_add_nonjump: pc=%h en=%b exp pc=4 en=0", pc, jmp_en);
    else passed++;
  endtask

  task automatic test_j();
    do_reset();
    advance(3);
    instr = J5;
    step();
    instr = NOP;
    total++;
    if (jmp_en !== 1'b1 || jmp_jump !== 1'b1 || jmp_path_index !== 4'd6 || jmp_pc !== 32'd3 ||
        jmp_addr !== 26'd5 || busy !== 1'b1 || pc_valid !== 1'b0 || pc !== 32'd3)
      $display("FAIL j_issue: en=%b jump=%b path=%0d jpc=%h addr=%h busy=%b pv=%b pc=%h exp 1 1 6 3 5 1 0 3",
               jmp_en, jmp_jump, jmp_path_index, jmp_pc, jmp_addr, busy, pc_valid, pc);
    else passed++;
    step();
    total++;
    if (jmp_en !== 1'b1 || jmp_addr !== 26'd5 || pc !== 32'd3)
      $display("FAIL j_hold: en=%b addr=%h pc=%h exp 1 5 3", jmp_en, jmp_addr, pc);
    else passed++;
    jmp_done = 1'b1; jmp_pc_out = 32'h14;
    step();
    jmp_done = 1'b0;
    total++;
    if (pc !== 32'h14 || pc_valid !== 1'b1 || jmp_en !== 1'b0 || busy !== 1'b0 || link_we !== 1'b0)
      $display("FAIL j_done: pc=%h pv=%b en=%b busy=%b lwe=%b exp 14 1 0 0 0",
               pc, pc_valid, jmp_en, busy, link_we);
    else passed++;
  endtask

  task automatic test_jal();
    do_reset();
    advance(3);
    instr = JAL0;
    step();
    instr = NOP;
    total++;
    if (jmp_path_index !== 4'd7 || jmp_en !== 1'b1)
      $display("FAIL jal_issue: path=%0d en=%b exp 7 1", jmp_path_index, jmp_en);
    else passed++;
    jmp_done = 1'b1; jmp_pc_out = 32'h20;
    step();
    jmp_done = 1'b0;
    total++;
    if (pc !== 32'h20 || link_we !== 1'b1 || link_data !== 32'd4)
      $display("FAIL jal_link: pc=%h lwe=%b ldata=%h exp 20 1 4", pc, link_we, link_data);
    else passed++;
    step();
    total++;
    if (link_we !== 1'b0 || pc !== 32'h21)
      $display("FAIL jal_link_pulse: lwe=%b pc=%h exp 0 21", link_we, pc);
    else passed++;
  endtask

  task automatic test_jr_stray_done();
    do_reset();
    advance(9);
    instr = JR_R1; rs_data = 32'd4;
    step();
    instr = NOP; rs_data = 32'hdead;
    total++;
    if (jmp_path_index !== 4'd8 || jmp_reg_addr !== 32'd4 || jmp_pc !== 32'd9)
      $display("FAIL jr_issue: path=%0d reg=%h jpc=%h exp 8 4 9", jmp_path_index, jmp_reg_addr, jmp_pc);
    else passed++;
    jmp_done = 1'b1; jmp_pc_out = 32'd4;
    step();
    total++;
    if (pc !== 32'd4 || link_we !== 1'b0 || jmp_en !== 1'b0)
      $display("FAIL jr_done: pc=%h lwe=%b en=%b exp 4 0 0", pc, link_we, jmp_en);
    else passed++;
    jmp_pc_out = 32'h77;
    step();
    jmp_done = 1'b0;
    total++;
    if (pc !== 32'd5 || jmp_en !== 1'b0)
      $display("FAIL stray_done_run: pc=%h en=%b exp 5 0", pc, jmp_en);
    else passed++;
  endtask

  task automatic test_pc_wrap();
    do_reset();
    instr = J5;
    step();
    instr = NOP;
    jmp_done = 1'b1; jmp_pc_out = 32'hFFFF_FFFF;
    step();
    jmp_done = 1'b0;
    step();
    total++;
    if (pc !== 32'd0 || pc_valid !== 1'b1)
      $display("FAIL pc_wrap: pc=%h pv=%b exp 0 1", pc, pc_valid);
    else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    instr = J5;
    step();
    instr = NOP;
    for (int i = 0; i < 15; i++) step();
    total++;
    if (busy !== 1'b1 || timeout_err !== 1'b0 || jmp_en !== 1'b1)
      $display("FAIL timeout_last_wait: busy=%b terr=%b en=%b exp 1 0 1", busy, timeout_err, jmp_en);
    else passed++;
    step();
    total++;
    if (timeout_err !== 1'b1 || jmp_en !== 1'b0 || busy !== 1'b0 || pc_valid !== 1'b0 || pc !== 32'd0)
      $display("FAIL timeout_fault: terr=%b en=%b busy=%b pv=%b pc=%h exp 1 0 0 0 0",
               timeout_err, jmp_en, busy, pc_valid, pc);
    else passed++;
    jmp_done = 1'b1; jmp_pc_out = 32'h40;
    step();
    jmp_done = 1'b0;
    step();
    total++;
    if (pc !== 32'd0 || timeout_err !== 1'b1 || pc_valid !== 1'b0)
      $display("FAIL fault_done_ignored: pc=%h terr=%b pv=%b exp 0 1 0", pc, timeout_err, pc_valid);
    else passed++;
    do_reset();
    total++;
    if (pc !== 32'd0 || timeout_err !== 1'b0 || pc_valid !== 1'b1)
      $display("FAIL fault_reset: pc=%h terr=%b pv=%b exp 0 0 1", pc, timeout_err, pc_valid);
    else passed++;
  endtask

  task automatic test_done_beats_timeout();
    do_reset();
    instr = J5;
    step();
    instr = NOP;
    for (int i = 0; i < 15; i++) step();
    jmp_done = 1'b1; jmp_pc_out = 32'h30;
    step();
    jmp_done = 1'b0;
    total++;
    if (pc !== 32'h30 || timeout_err !== 1'b0 || pc_valid !== 1'b1)
      $display("FAIL done_vs_timeout: pc=%h terr=%b pv=%b exp 30 0 1", pc, timeout_err, pc_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    advance(2);
    instr = J5;
    step();
    jmp_done = 1'b1; jmp_pc_out = 32'h50;
    step();
    jmp_done = 1'b0;
    // jump at the target is decoded now: en must be low this cycle, high next
    total++;
    if (jmp_en !== 1'b0 || pc !== 32'h50)
      $display("FAIL b2b_gap: en=%b pc=%h exp 0 50", jmp_en, pc);
    else passed++;
    step();
    instr = NOP;
    total++;
    if (jmp_en !== 1'b1 || jmp_pc !== 32'h50)
      $display("FAIL b2b_reissue: en=%b jpc=%h exp 1 50", jmp_en, jmp_pc);
    else passed++;
  endtask

  task automatic test_async_reset_and_stall();
    do_reset();
    advance(2);
    instr = J5;
    step();
    instr = NOP;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (jmp_en !== 1'b0 || busy !== 1'b0 || pc !== 32'd0 || pc_valid !== 1'b1)
      $display("FAIL async_reset_wait: en=%b busy=%b pc=%h pv=%b exp 0 0 0 1", jmp_en, busy, pc, pc_valid);
    else passed++;
    step();
    rst_n = 1'b1;
    advance(2);
    stall = 1'b1;
    step();
    total++;
    if (pc !== 32'd2)
      $display("FAIL stall_hold: pc=%h exp 2", pc);
    else passed++;
    instr = J5;
    step();
    step();
    total++;
    if (jmp_en !== 1'b0 || busy !== 1'b0 || pc !== 32'd2)
      $display("FAIL stall_no_issue: en=%b busy=%b pc=%h exp 0 0 2", jmp_en, busy, pc);
    else passed++;
    stall = 1'b0;
    step();
    instr = NOP;
    total++;
    if (jmp_en !== 1'b1 || jmp_pc !== 32'd2)
      $display("FAIL unstall_issue: en=%b jpc=%h exp 1 2", jmp_en, jmp_pc);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_j();
    test_jal();
    test_jr_stray_done();
    test_pc_wrap();
    test_timeout();
    test_done_beats_timeout();
    test_back_to_back();
    test_async_reset_and_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
